// File: rtl/sad_pkg.sv
// Shared definitions for the SAD pattern-match trigger.
//   - register bus addresses for reference, threshold and status
//   - status register bit positions
//   - sum-width helper used to size the SAD adder
package sad_pkg;

  localparam logic [7:0] SAD_REFERENCE = 8'h60;
  localparam logic [7:0] SAD_THRESHOLD = 8'h61;
  localparam logic [7:0] SAD_STATUS    = 8'h62;

  // SAD_STATUS byte 0 layout; bits 1..7 read as zero.
  localparam int STAT_TRIGGERED = 0;

  // Threshold register is 32 bits, little-endian over bytes 0..3.
  localparam int THR_W     = 32;
  localparam int THR_BYTES = THR_W / 8;

  // N terms of at most 2^W-1 each can never overflow W+clog2(N) bits.
  function automatic int sad_sum_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/sad_datapath.sv
// SAD datapath: sample window, per-lane absolute difference, adder tree, compare.
//   clk_adc, reset  : clock and synchronous active-high reset (flushes window and pipe)
//   adc_datain      : sample captured every edge (E0)
//   arm_i           : arm level; window valid count runs only while high
//   fire_en         : trigger qualifier from the arm logic, applied at the compare stage
//   ref_samples     : reference pattern, ref[0] pairs with the oldest sample
//   threshold       : strict-less compare limit
//   hit_d           : compare result about to be registered (E3 next-state)
//   hit_q           : registered compare result, i.e. the trigger pulse
module sad_datapath
  import sad_pkg::*;
#(
  parameter int pREF_SAMPLES     = 8,
  parameter int pBITS_PER_SAMPLE = 12
) (
  input  logic                                             clk_adc,
  input  logic                                             reset,
  input  logic [pBITS_PER_SAMPLE-1:0]                      adc_datain,
  input  logic                                             arm_i,
  input  logic                                             fire_en,
  input  logic [pREF_SAMPLES-1:0][pBITS_PER_SAMPLE-1:0]    ref_samples,
  input  logic [THR_W-1:0]                                 threshold,
  output logic                                             hit_d,
  output logic                                             hit_q
);

  localparam int N      = pREF_SAMPLES;
  localparam int W      = pBITS_PER_SAMPLE;
  localparam int SUM_W  = sad_sum_width(N, W);
  localparam int CNT_W  = $clog2(N + 1);
  localparam int CMP_W  = (SUM_W > THR_W) ? SUM_W : THR_W;
  localparam int STAGES = 2;

  logic [N-1:0][W-1:0] win_q;
  logic [N-1:0][W-1:0] absd_c;
  logic [N-1:0][W-1:0] diff_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STAGES:0]     vld_pipe;
  logic [SUM_W-1:0]    sum_c;
  logic [SUM_W-1:0]    sum_q;
  logic                full_c;

  // The sample landing now completes the window if N-1 armed samples precede it.
  assign full_c = arm_i && (cnt_q >= CNT_W'(N - 1));

  // Per-lane |s_i - ref_i|, unsigned, larger minus smaller so it never wraps.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign absd_c[i] = (win_q[i] >= ref_samples[i]) ? (win_q[i] - ref_samples[i])
                                                    : (ref_samples[i] - win_q[i]);
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) sum_c = sum_c + SUM_W'(diff_q[i]);
  end

  assign hit_d = vld_pipe[STAGES] && (CMP_W'(sum_q) < CMP_W'(threshold)) && fire_en;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      win_q    <= '0;
      cnt_q    <= '0;
      vld_pipe <= '0;
      diff_q   <= '0;
      sum_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      // E0: newest sample enters at the top, oldest falls out of index 0.
      win_q <= {adc_datain, win_q[N-1:1]};
      if (!arm_i)                  cnt_q <= '0;
      else if (cnt_q != CNT_W'(N)) cnt_q <= cnt_q + CNT_W'(1);
      vld_pipe <= {vld_pipe[STAGES-1:0], full_c};
      // E1 / E2 / E3
      diff_q <= absd_c;
      sum_q  <= sum_c;
      hit_q  <= hit_d;
    end
  end

endmodule

// File: rtl/sad_match_trigger.sv
// SAD pattern-match trigger on the ADC sample stream.
// Fires a one-cycle `trigger` when the sum of absolute differences between the
// last N samples and a programmed reference drops below a programmed threshold,
// at most once per rising edge of arm_i.
//   clk_adc, reset      : single clock, synchronous active-high reset
//   adc_datain          : ADC sample, captured every edge
//   arm_i               : arm level; rising edge re-arms, low disarms
//   reg_address/bytecnt : register bus select (reference, threshold, status)
//   reg_datai/reg_write : byte write, one per cycle
//   reg_datao/reg_read  : combinational byte read, zero when not reading
//   trigger             : single-cycle match pulse, 3 edges after the capture edge
module sad_match_trigger
  import sad_pkg::*;
#(
  parameter int pREF_SAMPLES     = 8,
  parameter int pBITS_PER_SAMPLE = 12,
  parameter int pBYTECNT_SIZE    = 7
) (
  input  logic                        clk_adc,
  input  logic                        reset,
  input  logic [pBITS_PER_SAMPLE-1:0] adc_datain,
  input  logic                        arm_i,
  input  logic [7:0]                  reg_address,
  input  logic [pBYTECNT_SIZE-1:0]    reg_bytecnt,
  input  logic [7:0]                  reg_datai,
  output logic [7:0]                  reg_datao,
  input  logic                        reg_read,
  input  logic                        reg_write,
  output logic                        trigger
);

  localparam int N         = pREF_SAMPLES;
  localparam int W         = pBITS_PER_SAMPLE;
  localparam int IDX_W     = $clog2(N);
  localparam int REF_BYTES = 2 * N;

  logic [N-1:0][W-1:0] ref_q, ref_d;
  logic [THR_W-1:0]    thr_q, thr_d;
  logic                arm_q;
  logic                armed_q;
  logic                stat_q;
  logic                arm_rise;
  logic                fire_en;
  logic                hit_d;
  logic                hit_q;
  logic                ref_in_range;
  logic                thr_in_range;
  logic [IDX_W-1:0]    smp_idx;
  logic [15:0]         ref_rd;
  logic [7:0]          rd_data;

  // Sample i lives at bytes 2i (low) and 2i+1 (high, zero-padded).
  assign smp_idx      = reg_bytecnt[IDX_W:1];
  assign ref_in_range = reg_bytecnt < pBYTECNT_SIZE'(REF_BYTES);
  assign thr_in_range = reg_bytecnt < pBYTECNT_SIZE'(THR_BYTES);

  // ---------------------------------------------------------------- writes
  always_comb begin
    ref_d = ref_q;
    thr_d = thr_q;
    if (reg_write) begin
      if (reg_address == SAD_REFERENCE && ref_in_range) begin
        if (reg_bytecnt[0]) ref_d[smp_idx][W-1:8] = reg_datai[W-9:0];
        else                ref_d[smp_idx][7:0]   = reg_datai;
      end else if (reg_address == SAD_THRESHOLD && thr_in_range) begin
        thr_d[{reg_bytecnt[1:0], 3'b000} +: 8] = reg_datai;
      end
    end
  end

  // ----------------------------------------------------------------- reads
  assign ref_rd = 16'(ref_q[smp_idx]);

  always_comb begin
    rd_data = '0;
    case (reg_address)
      SAD_REFERENCE: if (ref_in_range) rd_data = reg_bytecnt[0] ? ref_rd[15:8] : ref_rd[7:0];
      SAD_THRESHOLD: if (thr_in_range) rd_data = thr_q[{reg_bytecnt[1:0], 3'b000} +: 8];
      SAD_STATUS:    if (reg_bytecnt == '0) rd_data[STAT_TRIGGERED] = stat_q;
      default:       rd_data = '0;
    endcase
  end

  assign reg_datao = reg_read ? rd_data : 8'h00;

  // ------------------------------------------------------------ arm logic
  // Disarming wins over a coincident match: fire_en needs arm_i high at E3.
  assign arm_rise = arm_i && !arm_q;
  assign fire_en  = armed_q && arm_i;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      ref_q   <= '0;
      thr_q   <= '0;
      arm_q   <= 1'b0;
      armed_q <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      ref_q <= ref_d;
      thr_q <= thr_d;
      arm_q <= arm_i;
      // hit_d clears armed on the same edge the pulse is launched, so a
      // sustained match cannot produce a second pulse.
      if (arm_rise)              armed_q <= 1'b1;
      else if (!arm_i || hit_d)  armed_q <= 1'b0;
      if (arm_rise)   stat_q <= 1'b0;
      else if (hit_d) stat_q <= 1'b1;
    end
  end

  sad_datapath #(
    .pREF_SAMPLES     (N),
    .pBITS_PER_SAMPLE (W)
  ) u_datapath (
    .clk_adc     (clk_adc),
    .reset       (reset),
    .adc_datain  (adc_datain),
    .arm_i       (arm_i),
    .fire_en     (fire_en),
    .ref_samples (ref_q),
    .threshold   (thr_q),
    .hit_d       (hit_d),
    .hit_q       (hit_q)
  );

  assign trigger = hit_q;

endmodule

// File: tb/tb_sad_match_trigger.sv
module tb_sad_match_trigger;
  localparam int N = 8;
  localparam int W = 12;

  logic         clk_adc = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] adc_datain = '0;
  logic         arm_i = 1'b0;
  logic [7:0]   reg_address = '0;
  logic [6:0]   reg_bytecnt = '0;
  logic [7:0]   reg_datai = '0;
  logic [7:0]   reg_datao;
  logic         reg_read = 1'b0;
  logic         reg_write = 1'b0;
  logic         trigger;

  always #5 clk_adc = ~clk_adc;

  sad_match_trigger #(.pREF_SAMPLES(N), .pBITS_PER_SAMPLE(W), .pBYTECNT_SIZE(7)) dut (
    .clk_adc(clk_adc), .reset(reset), .adc_datain(adc_datain), .arm_i(arm_i),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
    .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write), .trigger(trigger)
  );

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;

  // Reference model state
  logic [W-1:0] mref[N];
  logic [31:0]  mthr = '0;
  logic [W-1:0] mwin[N];
  int           mcnt = 0;
  bit           m_armed = 0, m_armq = 0, m_stat = 0;
  bit           mq[$];  // expected window-match per captured sample, 4 negedges deep

  // Runs at a negedge: the posedge just before it used the current reset/arm_i.
  task automatic check();
    bit mt, exp_t, rise;
    mt = mq.pop_front();
    if (reset) begin
      foreach (mq[i]) mq[i] = 0;
      exp_t = 0; m_armed = 0; m_armq = 0; m_stat = 0;
    end else begin
      rise  = arm_i && !m_armq;
      exp_t = mt && m_armed && arm_i;
      if (rise) m_armed = 1;
      else if (!arm_i || exp_t) m_armed = 0;
      if (rise) m_stat = 0;
      else if (exp_t) m_stat = 1;
      m_armq = arm_i;
    end
    n_checks++;
    if (trigger !== exp_t) begin
      n_fail++;
      $display("FAIL trigger @%0t: got %b expected %b", $time, trigger, exp_t);
    end
    if (trigger === 1'b1) pulses++;
  endtask

  // One clock: check the previous edge, then drive the next sample and push its expectation.
  task automatic step(input logic [W-1:0] s, input bit a, input bit r);
    int sad;
    @(negedge clk_adc);
    check();
    reg_write = 0; reg_read = 0;
    adc_datain = s; arm_i = a; reset = r;
    if (r) begin
      foreach (mwin[i]) mwin[i] = '0;
      foreach (mref[i]) mref[i] = '0;
      mthr = '0; mcnt = 0;
      mq.push_back(0);
    end else begin
      for (int i = 0; i < N - 1; i++) mwin[i] = mwin[i + 1];
      mwin[N - 1] = s;
      mcnt = a ? ((mcnt < N) ? mcnt + 1 : N) : 0;
      sad = 0;
      for (int i = 0; i < N; i++) begin
        int d;
        d = int'(mwin[i]) - int'(mref[i]);
        sad += (d < 0) ? -d : d;
      end
      mq.push_back(a && (mcnt == N) && (longint'(sad) < longint'(mthr)));
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    step('0, 0, 0);
    reg_address = a; reg_bytecnt = bc; reg_datai = d; reg_write = 1;
    if (a == 8'h60 && bc < 2 * N) begin
      if (bc[0]) mref[bc >> 1][11:8] = d[3:0];
      else       mref[bc >> 1][7:0]  = d;
    end else if (a == 8'h61 && bc < 4) begin
      mthr[8 * bc +: 8] = d;
    end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [6:0] bc,
                        input logic [7:0] exp);
    step('0, arm_i, 0);
    reg_address = a; reg_bytecnt = bc; reg_read = 1;
    #1;
    n_checks++;
    if (reg_datao !== exp) begin
      n_fail++;
      $display("FAIL %s: reg_datao=%h expected %h", name, reg_datao, exp);
    end
  endtask

  task automatic chk_pulses(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: pulses=%0d expected %0d", name, got, exp);
    end
  endtask

  task automatic prog_pattern();
    for (int i = 0; i < N; i++) begin
      logic [15:0] v;
      v = 16'((i + 1) * 100);
      wr(8'h60, 7'(2 * i), v[7:0]);
      wr(8'h60, 7'(2 * i + 1), v[15:8]);
    end
  endtask

  task automatic prog_thr(input logic [31:0] t);
    for (int b = 0; b < 4; b++) wr(8'h61, 7'(b), t[8 * b +: 8]);
  endtask

  // Drive the last `cnt` samples of the reference pattern with deviations on samples 2 and 5.
  task automatic pat(input int d2, input int d5, input int cnt, input bit a);
    for (int i = N - cnt; i < N; i++) begin
      int v;
      v = (i + 1) * 100 + ((i == 2) ? d2 : 0) + ((i == 5) ? d5 : 0);
      step(W'(v), a, 0);
    end
  endtask

  task automatic idle(input int n, input bit a);
    repeat (n) step('0, a, 0);
  endtask

  task automatic test_reset();
    step('0, 0, 1); step('0, 0, 1); step('0, 0, 0);
    n_checks++;
    if (trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger: got %b expected 0", trigger); end
    rd_chk("reset_ref0", 8'h60, 0, 8'h00);
    rd_chk("reset_ref15", 8'h60, 15, 8'h00);
    rd_chk("reset_thr0", 8'h61, 0, 8'h00);
    rd_chk("reset_status", 8'h62, 0, 8'h00);
  endtask

  task automatic test_regs();
    logic [31:0] t;
    t = 32'h12345678;
    prog_pattern();
    prog_thr(t);
    for (int b = 0; b < 4; b++) rd_chk("thr_rb", 8'h61, 7'(b), t[8 * b +: 8]);
    for (int i = 0; i < N; i++) begin
      logic [15:0] v;
      v = 16'((i + 1) * 100);
      rd_chk("ref_rb_lo", 8'h60, 7'(2 * i), v[7:0]);
      rd_chk("ref_rb_hi", 8'h60, 7'(2 * i + 1), v[15:8]);
    end
    rd_chk("ref_oob", 8'h60, 16, 8'h00);
    rd_chk("thr_oob", 8'h61, 4, 8'h00);
    rd_chk("unmapped", 8'h63, 0, 8'h00);
    rd_chk("status_b1", 8'h62, 1, 8'h00);
    wr(8'h60, 16, 8'hAA);
    rd_chk("ref_oob_wr", 8'h60, 0, 8'h64);
    wr(8'h60, 1, 8'hFF);
    rd_chk("ref_hi_pad", 8'h60, 1, 8'h0F);
    wr(8'h60, 1, 8'h00);
    prog_thr(32'd50);
  endtask

  task automatic test_exact();
    int p0;
    p0 = pulses;
    repeat (20) step(W'($urandom_range(4095)), 1, 0);
    pat(0, 0, N, 1);
    idle(5, 1);
    rd_chk("exact_status", 8'h62, 0, 8'h01);
    chk_pulses("exact_pulses", pulses - p0, 1);
    idle(2, 0);
  endtask

  task automatic test_boundary();
    int p0;
    p0 = pulses;
    pat(30, -19, N, 1);
    idle(5, 1);
    chk_pulses("sad49_pulses", pulses - p0, 1);
    idle(2, 0);
    p0 = pulses;
    pat(30, -20, N, 1);
    idle(5, 1);
    chk_pulses("sad50_pulses", pulses - p0, 0);
    rd_chk("sad50_status", 8'h62, 0, 8'h00);
    idle(2, 0);
  endtask

  task automatic test_unarmed();
    int p0;
    p0 = pulses;
    pat(0, 0, N, 0);
    idle(5, 0);
    chk_pulses("unarmed_pulses", pulses - p0, 0);
    rd_chk("unarmed_status", 8'h62, 0, 8'h00);
    step(W'(100), 0, 0);
    pat(0, 0, N - 1, 1);
    idle(5, 1);
    chk_pulses("partial_pulses", pulses - p0, 0);
    idle(2, 0);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses;
    pat(0, 0, N, 1);
    pat(0, 0, N, 1);
    idle(5, 1);
    chk_pulses("b2b_pulses", pulses - p0, 1);
    rd_chk("b2b_status", 8'h62, 0, 8'h01);
    idle(2, 0);
    step('0, 1, 0);
    rd_chk("rearm_status", 8'h62, 0, 8'h00);
    pat(0, 0, N, 1);
    idle(5, 1);
    chk_pulses("rearm_pulses", pulses - p0, 2);
    rd_chk("rearm_status2", 8'h62, 0, 8'h01);
    idle(2, 0);
  endtask

  task automatic test_overflow();
    int p0;
    for (int b = 0; b < 2 * N; b++) wr(8'h60, 7'(b), 8'h00);
    prog_thr(32'hFFFF_FFFF);
    p0 = pulses;
    repeat (12) step(W'(4095), 1, 0);
    idle(2, 0);
    chk_pulses("ovf_max_thr", pulses - p0, 1);
    prog_thr(32'd32760);
    p0 = pulses;
    repeat (12) step(W'(4095), 1, 0);
    idle(2, 0);
    chk_pulses("ovf_eq_thr", pulses - p0, 0);
    prog_thr(32'd32761);
    p0 = pulses;
    repeat (12) step(W'(4095), 1, 0);
    idle(2, 0);
    chk_pulses("ovf_thr_plus1", pulses - p0, 1);
  endtask

  task automatic test_reset_mid();
    int p0;
    prog_pattern();
    prog_thr(32'd50);
    p0 = pulses;
    for (int i = 0; i < 5; i++) step(W'((i + 1) * 100), 1, 0);
    step('0, 1, 1);
    for (int i = 5; i < N; i++) step(W'((i + 1) * 100), 1, 0);
    idle(5, 1);
    chk_pulses("rstmid_pulses", pulses - p0, 0);
    n_checks++;
    if (trigger !== 1'b0) begin n_fail++; $display("FAIL rstmid_trigger: got %b expected 0", trigger); end
    rd_chk("rstmid_status", 8'h62, 0, 8'h00);
    rd_chk("rstmid_ref", 8'h60, 0, 8'h00);
    rd_chk("rstmid_thr", 8'h61, 0, 8'h00);
    idle(2, 0);
  endtask

  initial begin
    foreach (mref[i]) mref[i] = '0;
    foreach (mwin[i]) mwin[i] = '0;
    repeat (4) mq.push_back(0);
    test_reset();
    test_regs();
    test_exact();
    test_boundary();
    test_unarmed();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
